mem_arbiter: RTL

- Two-master, one-slave arbiter that shares the single-port RAM between the CPU (master 0) and a second bus master (master 1, e.g. a DMA or boot loader).
- Uses the SoC memory bus signal set: addr, rstrb, wdata, wmask, rdata.
- Adds busy/done handshakes to each master. The arbiter alone drives the RAM port.
- Sits between the masters and the RAM in the SoC top level. IO decode stays on the master side.

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port RAM.
// Define MEM_ARB_PERF_EN to add the per-master saturating grant counters.
module mem_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef MEM_ARB_PERF_EN
  output logic [15:0] m0_grants,
  output logic [15:0] m1_grants,
`endif
  input  logic [31:0] m0_addr,
  input  logic        m0_rstrb,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic [31:0] m0_rdata,
  output logic        m0_busy,
  output logic        m0_done,
  input  logic [31:0] m1_addr,
  input  logic        m1_rstrb,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic [31:0] m1_rdata,
  output logic        m1_busy,
  output logic        m1_done,
  output logic [31:0] s_addr,
  output logic        s_rstrb,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  input  logic [31:0] s_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state;
  logic [1:0]       req;
  logic [1:0]       busy;
  logic [1:0]       done;
  logic [1:0]       wr;
  logic [1:0][31:0] in_addr;
  logic [1:0][31:0] in_wdata;
  logic [1:0][3:0]  in_wmask;
  logic [1:0][31:0] sl_addr;
  logic [1:0][31:0] sl_wdata;
  logic [1:0][3:0]  sl_wmask;
  logic [1:0][31:0] rd;
  logic             last_grant;
  logic             cur;
  logic             win;
  logic [2:0]       cnt;

  assign in_addr  = {m1_addr, m0_addr};
  assign in_wdata = {m1_wdata, m0_wdata};
  assign in_wmask = {m1_wmask, m0_wmask};
  assign req[0]   = m0_rstrb | (|m0_wmask);
  assign req[1]   = m1_rstrb | (|m1_wmask);

  assign m0_busy  = busy[0];
  assign m1_busy  = busy[1];
  assign m0_done  = done[0];
  assign m1_done  = done[1];
  assign m0_rdata = rd[0];
  assign m1_rdata = rd[1];

  // Tie goes to the master that was not granted last.
  assign win = (&busy) ? ~last_grant : busy[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= '0;
      done       <= '0;
      wr         <= '0;
      sl_addr    <= '0;
      sl_wdata   <= '0;
      sl_wmask   <= '0;
      rd         <= '0;
      last_grant <= 1'b1;
      cur        <= 1'b0;
      cnt        <= '0;
      s_addr     <= '0;
      s_rstrb    <= 1'b0;
      s_wdata    <= '0;
      s_wmask    <= '0;
    end else begin
      done <= '0;
      for (int i = 0; i < 2; i++) begin
        if (!busy[i] && req[i]) begin
          busy[i]     <= 1'b1;
          sl_addr[i]  <= in_addr[i];
          sl_wdata[i] <= in_wdata[i];
          sl_wmask[i] <= in_wmask[i];
          wr[i]       <= |in_wmask[i];
        end
      end
      unique case (state)
        IDLE: begin
          if (|busy) begin
            cur        <= win;
            last_grant <= win;
            s_addr     <= sl_addr[win];
            s_wdata    <= sl_wdata[win];
            if (wr[win]) s_wmask <= sl_wmask[win];
            else         s_rstrb <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          s_rstrb <= 1'b0;
          s_wmask <= '0;
          if (wr[cur]) begin
            done[cur] <= 1'b1;
            busy[cur] <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt   <= 3'(RD_LATENCY);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            rd[cur]   <= s_rdata;
            done[cur] <= 1'b1;
            busy[cur] <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [1:0][15:0] grants;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grants <= '0;
    end else if (state == ISSUE && grants[cur] != 16'hFFFF) begin
      grants[cur] <= grants[cur] + 16'd1;
    end
  end

  assign m0_grants = grants[0];
  assign m1_grants = grants[1];
`endif

endmodule
